sd_dma_sequencer: RTL and testbench
===================================

SD_DMA_SEQUENCER -- requirements
Module: sd_dma_sequencer

Interface
REQ-001 Parameter TMO_W, default 24: width of the inactivity timeout counter.
REQ-002 Parameter TMO_VAL, default 24'hFFFFFF: inactivity limit in wb_clk cycles.
REQ-003 wb_clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  one-cycle transfer request.
REQ-006 abort_i  in  1  one-cycle abort request.
REQ-007 dir_i  in  1  direction: 1 = card-to-memory (rx), 0 = memory-to-card (tx); sampled on start.
REQ-008 dma_adr_i  in  32  memory base byte address; sampled on start.
REQ-009 blk_size_i  in  12  block size in bytes; sampled on start.
REQ-010 blk_cnt_i  in  16  number of blocks minus one; sampled on start.
REQ-011 en_rx_o / en_tx_o  out  1 each  fifo-filler enables.
REQ-012 adr_o  out  32  base address to fifo filler.
REQ-013 wbm_cyc_i, wbm_stb_i, wbm_ack_i  in  1 each  filler bus-master monitor.
REQ-014 wb_full_i, wb_empty_i  in  1 each  filler wb-side fifo flags.
REQ-015 blk_start_o  out  1  one-cycle pulse: serial engine starts one block.
REQ-016 blk_done_i  in  1  one-cycle pulse: serial engine finished one block.
REQ-017 blk_crc_err_i  in  1  valid with blk_done_i: block CRC/status failed.
REQ-018 busy_o  out  1  transfer in progress.
REQ-019 irq_o  out  1  level: transfer ended (done or error); cleared by next accepted start.
REQ-020 err_o  out  3  0 none, 1 CRC, 2 timeout, 3 abort, 4 bad parameter.
REQ-021 xfer_cnt_o  out  27  words moved on the bus in current/last transfer.

Function
REQ-022 States: IDLE, SETUP, PREFILL, RUN, NEXT, DRAIN, DONE, ERROR.
REQ-023 IDLE: start_i latches dir, address, size, count; clears err_o, irq_o, xfer_cnt_o; goes to SETUP. start_i outside IDLE/DONE/ERROR is ignored.
REQ-024 SETUP (1 cycle): wpb = ceil(blk_size/4) (11 bits); total = (blk_cnt+1)*wpb (27 bits); blk_size 0 -> ERROR, err 4; otherwise assert en_rx_o (dir=1) or en_tx_o (dir=0); rx -> NEXT, tx -> PREFILL.
REQ-025 adr_o equals latched dma_adr_i from SETUP until IDLE/DONE/ERROR; enable stays asserted across all blocks of a transfer (the filler advances its own offset).
REQ-026 Beat = wbm_cyc_i & wbm_stb_i & wbm_ack_i while an enable is high; each beat increments xfer_cnt_o by 1, saturating at total.
REQ-027 PREFILL: leave for NEXT when wb_full_i=1 or xfer_cnt_o==total.
REQ-028 NEXT (1 cycle): blk_start_o=1, increment block index, go to RUN.
REQ-029 RUN: on blk_done_i: crc err -> ERROR err 1; else if index==blk_cnt+1 -> DRAIN (rx) or DONE (tx); else -> NEXT.
REQ-030 DRAIN: go to DONE when wb_empty_i=1 and xfer_cnt_o==total.
REQ-031 DONE/ERROR: enables low, busy_o low, irq_o high; start_i accepted as in IDLE.
REQ-032 busy_o high in SETUP..DRAIN only.
REQ-033 Timeout counter: reset on entry to SETUP, on every beat, on blk_done_i; increments otherwise in PREFILL/RUN/DRAIN; reaching TMO_VAL -> ERROR err 2.
REQ-034 abort_i in any busy state -> ERROR err 3 next cycle; enables drop that cycle (filler fifo/offset reset).
REQ-035 Priority in one cycle: abort > crc error > progress (beat/blk_done) > timeout.
REQ-036 abort_i in IDLE/DONE/ERROR: no effect.
REQ-037 blk_start_o never asserted twice without an intervening blk_done_i.

Reset
REQ-038 rst: state IDLE; en_rx_o, en_tx_o, blk_start_o, busy_o, irq_o = 0; adr_o=0; err_o=0; xfer_cnt_o=0; timeout 0; rst mid-transfer drops enables immediately.

Verification
REQ-039 rx, adr 0x1000, size 512, cnt 1: 2 blk_start pulses, 256 beats, DRAIN until empty -> irq=1, err=0, xfer_cnt=256.
REQ-040 tx, size 512, cnt 0, fifo full after 64 beats: blk_start only after wb_full_i; DONE after blk_done, xfer_cnt=128.
REQ-041 rx, cnt 3, blk_crc_err_i on 2nd blk_done -> ERROR err 1, enables low, no 3rd blk_start.
REQ-042 No acks or blk_done for TMO_VAL (bench TMO_VAL=100) -> ERROR err 2 at cycle 100; ack at cycle 99 restarts count.
REQ-043 abort_i coincident with blk_done_i in RUN -> err 3; blk_size_i=0 start -> err 4, enables never high.
REQ-044 rst asserted mid-RUN -> all outputs zero asynchronously; new start afterwards completes normally.

Source files
------------

// File: rtl/sd_dma_sequencer.sv
// SD DMA transfer sequencer: paces the fifo filler and the serial block engine,
// counts bus beats and reports completion, timeout, abort or CRC failure.
module sd_dma_sequencer #(
  parameter int unsigned      TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_VAL = 24'hFFFFFF
) (
  input  logic        wb_clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        dir_i,
  input  logic [31:0] dma_adr_i,
  input  logic [11:0] blk_size_i,
  input  logic [15:0] blk_cnt_i,
  output logic        en_rx_o,
  output logic        en_tx_o,
  output logic [31:0] adr_o,
  input  logic        wbm_cyc_i,
  input  logic        wbm_stb_i,
  input  logic        wbm_ack_i,
  input  logic        wb_full_i,
  input  logic        wb_empty_i,
  output logic        blk_start_o,
  input  logic        blk_done_i,
  input  logic        blk_crc_err_i,
  output logic        busy_o,
  output logic        irq_o,
  output logic [2:0]  err_o,
  output logic [26:0] xfer_cnt_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] PREFILL = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] NEXT    = 3'd4;
  localparam logic [2:0] DRAIN   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [2:0] ERROR   = 3'd7;

  localparam logic [2:0] ERR_CRC   = 3'd1;
  localparam logic [2:0] ERR_TMO   = 3'd2;
  localparam logic [2:0] ERR_ABORT = 3'd3;
  localparam logic [2:0] ERR_PARAM = 3'd4;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_VAL - TMO_W'(1);

  logic [2:0]       state;
  logic             dir_q;
  logic [31:0]      adr_q;
  logic [11:0]      size_q;
  logic [15:0]      cnt_q;
  logic [16:0]      blk_idx;
  logic [TMO_W-1:0] tmo;

  logic [10:0] wpb;
  logic [16:0] blk_total;
  logic [26:0] total;
  logic        en_active;
  logic        beat;
  logic        progress;
  logic        tmo_run;
  logic        tmo_exp;

  assign wpb       = 11'(({1'b0, size_q} + 13'd3) >> 2);
  assign blk_total = {1'b0, cnt_q} + 17'd1;
  assign total     = 27'(blk_total) * 27'(wpb);

  assign busy_o = (state != IDLE) && (state != DONE) && (state != ERROR);

  // Abort drops the enables combinationally so the filler resets in the same cycle.
  assign en_active = busy_o && !abort_i && !((state == SETUP) && (size_q == '0));
  assign en_rx_o   = en_active && dir_q;
  assign en_tx_o   = en_active && !dir_q;
  assign adr_o     = busy_o ? adr_q : '0;

  assign blk_start_o = (state == NEXT);

  assign beat     = wbm_cyc_i && wbm_stb_i && wbm_ack_i && en_active;
  assign progress = beat || blk_done_i;
  assign tmo_run  = (state == PREFILL) || (state == RUN) || (state == DRAIN);
  assign tmo_exp  = !progress && (tmo == TMO_LAST);

  always_ff @(posedge wb_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      adr_q      <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      blk_idx    <= '0;
      tmo        <= '0;
      xfer_cnt_o <= '0;
      err_o      <= '0;
      irq_o      <= 1'b0;
    end else if (!busy_o) begin
      if (start_i) begin
        state      <= SETUP;
        dir_q      <= dir_i;
        adr_q      <= dma_adr_i;
        size_q     <= blk_size_i;
        cnt_q      <= blk_cnt_i;
        blk_idx    <= '0;
        tmo        <= '0;
        xfer_cnt_o <= '0;
        err_o      <= '0;
        irq_o      <= 1'b0;
      end
    end else if (abort_i) begin
      state <= ERROR;
      err_o <= ERR_ABORT;
      irq_o <= 1'b1;
    end else begin
      if (beat && (xfer_cnt_o < total))
        xfer_cnt_o <= xfer_cnt_o + 27'd1;
      if (progress)
        tmo <= '0;
      else if (tmo_run)
        tmo <= tmo + TMO_W'(1);

      case (state)
        SETUP: begin
          if (size_q == '0) begin
            state <= ERROR;
            err_o <= ERR_PARAM;
            irq_o <= 1'b1;
          end else begin
            state <= dir_q ? NEXT : PREFILL;
          end
        end
        PREFILL: begin
          if (wb_full_i || (xfer_cnt_o == total)) begin
            state <= NEXT;
          end else if (tmo_exp) begin
            state <= ERROR;
            err_o <= ERR_TMO;
            irq_o <= 1'b1;
          end
        end
        NEXT: begin
          blk_idx <= blk_idx + 17'd1;
          state   <= RUN;
        end
        RUN: begin
          if (blk_done_i) begin
            if (blk_crc_err_i) begin
              state <= ERROR;
              err_o <= ERR_CRC;
              irq_o <= 1'b1;
            end else if (blk_idx == blk_total) begin
              state <= dir_q ? DRAIN : DONE;
              irq_o <= !dir_q;
            end else begin
              state <= NEXT;
            end
          end else if (tmo_exp) begin
            state <= ERROR;
            err_o <= ERR_TMO;
            irq_o <= 1'b1;
          end
        end
        DRAIN: begin
          if (wb_empty_i && (xfer_cnt_o == total)) begin
            state <= DONE;
            irq_o <= 1'b1;
          end else if (tmo_exp) begin
            state <= ERROR;
            err_o <= ERR_TMO;
            irq_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_dma_sequencer.sv
// Randomized bench for sd_dma_sequencer: filler/engine models drive the DUT and a
// transfer-level reference (beats, block starts, expected totals) checks results.
`timescale 1ns/1ps
module tb_sd_dma_sequencer;

  logic        wb_clk = 1'b0;
  logic        rst;
  logic        start_i, abort_i, dir_i;
  logic [31:0] dma_adr_i;
  logic [11:0] blk_size_i;
  logic [15:0] blk_cnt_i;
  logic        en_rx_o, en_tx_o;
  logic [31:0] adr_o;
  logic        wbm_cyc_i, wbm_stb_i, wbm_ack_i, wb_full_i, wb_empty_i;
  logic        blk_start_o, blk_done_i, blk_crc_err_i;
  logic        busy_o, irq_o;
  logic [2:0]  err_o;
  logic [26:0] xfer_cnt_o;

  sd_dma_sequencer #(.TMO_W(24), .TMO_VAL(24'd100)) dut (
    .wb_clk(wb_clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .dir_i(dir_i),
    .dma_adr_i(dma_adr_i), .blk_size_i(blk_size_i), .blk_cnt_i(blk_cnt_i),
    .en_rx_o(en_rx_o), .en_tx_o(en_tx_o), .adr_o(adr_o),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_ack_i(wbm_ack_i),
    .wb_full_i(wb_full_i), .wb_empty_i(wb_empty_i),
    .blk_start_o(blk_start_o), .blk_done_i(blk_done_i), .blk_crc_err_i(blk_crc_err_i),
    .busy_o(busy_o), .irq_o(irq_o), .err_o(err_o), .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 wb_clk = ~wb_clk;

  int vectors = 0;
  int miscompares = 0;

  // environment knobs
  int ack_pct, empty_pct, full_at, crc_blk, eng_min, eng_max;
  bit eng_off, abort_with_done, noise_start, force_ack;

  // transfer-level reference state
  int          m_total, m_beats, m_starts, m_dones, m_double, m_beats_first_start;
  int          m_adr_bad, m_dir_bad, eng_cd;
  bit          m_out, m_en_seen, m_en_on_abort, m_dir;
  logic [31:0] m_adr;

  task automatic idle_inputs();
    start_i = 0; abort_i = 0; wbm_cyc_i = 0; wbm_stb_i = 0; wbm_ack_i = 0;
    wb_full_i = 0; wb_empty_i = 0; blk_done_i = 0; blk_crc_err_i = 0;
  endtask

  task automatic set_env(input int ack, input int empty, input int full, input int crc,
                         input int emin, input int emax);
    ack_pct = ack; empty_pct = empty; full_at = full; crc_blk = crc;
    eng_min = emin; eng_max = emax; eng_off = 0; abort_with_done = 0;
    noise_start = 0; force_ack = 0;
  endtask

  // Called at a negedge: presents a start request and returns at the next negedge.
  task automatic do_start(input bit dir, input logic [31:0] adr, input int size, input int cnt);
    idle_inputs();
    dir_i = dir; dma_adr_i = adr; blk_size_i = size[11:0]; blk_cnt_i = cnt[15:0]; start_i = 1;
    m_dir = dir; m_adr = adr; m_total = (cnt + 1) * ((size + 3) / 4);
    m_beats = 0; m_starts = 0; m_dones = 0; m_double = 0; m_beats_first_start = -1;
    m_adr_bad = 0; m_dir_bad = 0; eng_cd = 0; m_out = 0; m_en_seen = 0; m_en_on_abort = 0;
    @(negedge wb_clk);
    start_i = 0;
  endtask

  // One clock of filler + serial engine behaviour; starts and ends on a negedge.
  task automatic run_cycle();
    bit a, en;
    wb_full_i = (full_at >= 0) && (m_beats >= full_at) && (m_starts == 0);
    a = (force_ack || ($urandom_range(99) < ack_pct)) && !wb_full_i;
    wbm_cyc_i = a || ($urandom_range(3) == 0);
    wbm_stb_i = wbm_cyc_i;
    wbm_ack_i = a;
    wb_empty_i = ($urandom_range(99) < empty_pct);
    blk_done_i = 0; blk_crc_err_i = 0; abort_i = 0;
    if (eng_cd > 0) begin
      eng_cd--;
      if (eng_cd == 0) begin
        blk_done_i = 1; m_dones++; m_out = 0;
        blk_crc_err_i = (m_dones == crc_blk);
        abort_i = abort_with_done;
      end
    end
    start_i = noise_start && ($urandom_range(19) == 0);
    if (start_i) begin
      dma_adr_i = $urandom; blk_size_i = 12'($urandom); blk_cnt_i = 16'($urandom); dir_i = 1'($urandom);
    end
    #1;
    en = en_rx_o || en_tx_o;
    if (en) m_en_seen = 1;
    if (abort_i && en) m_en_on_abort = 1;
    if ((en_rx_o && !m_dir) || (en_tx_o && m_dir)) m_dir_bad++;
    if (busy_o && (adr_o !== m_adr)) m_adr_bad++;
    if (blk_start_o) begin
      if (m_out) m_double++;
      if (m_starts == 0) m_beats_first_start = m_beats;
      m_out = 1; m_starts++;
      if (!eng_off) eng_cd = $urandom_range(eng_max, eng_min);
    end
    if (a && en && (m_beats < m_total)) m_beats++;
    @(negedge wb_clk);
  endtask

  task automatic run_to_end(output bit expired);
    int n;
    n = 0;
    while (busy_o && n < 20000) begin
      run_cycle();
      n++;
    end
    expired = busy_o;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    vectors++;
    if ({en_rx_o, en_tx_o, blk_start_o, busy_o, irq_o, err_o, adr_o, xfer_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b irq=%b err=%0d adr=%h xfer=%0d, required all zero",
               busy_o, irq_o, err_o, adr_o, xfer_cnt_o);
    end
    repeat (3) @(negedge wb_clk);
    rst = 0;
    @(negedge wb_clk);
    vectors++;
    if (busy_o !== 1'b0 || irq_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b irq=%b, required 0 0", busy_o, irq_o);
    end
  endtask

  task automatic test_rx_two_blocks();
    bit exp;
    set_env(60, 30, -1, 0, 80, 140);
    noise_start = 1;
    do_start(1, 32'h0000_1000, 512, 1);
    vectors++;
    if (busy_o !== 1 || irq_o !== 0 || en_rx_o !== 1 || en_tx_o !== 0 || adr_o !== 32'h1000) begin
      miscompares++;
      $display("FAIL rx2_setup: busy=%b irq=%b en_rx=%b en_tx=%b adr=%h, required 1 0 1 0 00001000",
               busy_o, irq_o, en_rx_o, en_tx_o, adr_o);
    end
    run_to_end(exp);
    vectors++;
    if (exp) begin miscompares++; $display("FAIL rx2_budget: still busy, required done"); end
    vectors++;
    if (m_starts != 2) begin miscompares++; $display("FAIL rx2_starts: got %0d required 2", m_starts); end
    vectors++;
    if (xfer_cnt_o !== 27'd256) begin
      miscompares++; $display("FAIL rx2_xfer: got %0d required 256", xfer_cnt_o);
    end
    vectors++;
    if (irq_o !== 1 || err_o !== 3'd0 || en_rx_o !== 0) begin
      miscompares++; $display("FAIL rx2_end: irq=%b err=%0d en_rx=%b, required 1 0 0", irq_o, err_o, en_rx_o);
    end
    vectors++;
    if (m_double != 0 || m_adr_bad != 0 || m_dir_bad != 0) begin
      miscompares++;
      $display("FAIL rx2_protocol: double_start=%0d adr_bad=%0d dir_bad=%0d, required 0 0 0",
               m_double, m_adr_bad, m_dir_bad);
    end
  endtask

  task automatic test_tx_prefill();
    bit exp;
    set_env(70, 0, 64, 0, 200, 260);
    do_start(0, $urandom, 512, 0);
    run_to_end(exp);
    vectors++;
    if (exp) begin miscompares++; $display("FAIL tx_budget: still busy, required done"); end
    vectors++;
    if (m_beats_first_start != 64) begin
      miscompares++; $display("FAIL tx_prefill: beats at blk_start %0d required 64", m_beats_first_start);
    end
    vectors++;
    if (m_starts != 1) begin miscompares++; $display("FAIL tx_starts: got %0d required 1", m_starts); end
    vectors++;
    if (xfer_cnt_o !== 27'd128 || irq_o !== 1 || err_o !== 0) begin
      miscompares++;
      $display("FAIL tx_end: xfer=%0d irq=%b err=%0d, required 128 1 0", xfer_cnt_o, irq_o, err_o);
    end
  endtask

  task automatic test_crc_error();
    bit exp;
    set_env(60, 30, -1, 2, 5, 60);
    do_start(1, $urandom, $urandom_range(2048, 1), 3);
    run_to_end(exp);
    repeat (50) run_cycle();
    idle_inputs();
    vectors++;
    if (exp || err_o !== 3'd1 || irq_o !== 1) begin
      miscompares++; $display("FAIL crc_err: err=%0d irq=%b expired=%b, required 1 1 0", err_o, irq_o, exp);
    end
    vectors++;
    if (m_starts != 2 || en_rx_o !== 0 || en_tx_o !== 0) begin
      miscompares++;
      $display("FAIL crc_stop: starts=%0d en_rx=%b en_tx=%b, required 2 0 0", m_starts, en_rx_o, en_tx_o);
    end
    vectors++;
    if (xfer_cnt_o !== 27'(m_beats)) begin
      miscompares++; $display("FAIL crc_xfer: got %0d required %0d", xfer_cnt_o, m_beats);
    end
  endtask

  // Timeout fires after 100 consecutive idle cycles in RUN; an ack restarts the count.
  task automatic test_timeout();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      set_env(0, 0, -1, 0, 1, 1);
      eng_off = 1;
      do_start(1, $urandom, 64, 0);
      n = 0;
      while (m_starts == 0 && n < 20) begin run_cycle(); n++; end
      for (int c = 1; c <= 98; c++) run_cycle();
      if (pass == 1) force_ack = 1;
      run_cycle();
      force_ack = 0;
      if (pass == 1) for (int c = 0; c < 99; c++) run_cycle();
      vectors++;
      if (busy_o !== 1) begin
        miscompares++; $display("FAIL tmo_early_%0d: busy=%b err=%0d, required busy", pass, busy_o, err_o);
      end
      run_cycle();
      idle_inputs();
      vectors++;
      if (busy_o !== 0 || err_o !== 3'd2 || irq_o !== 1) begin
        miscompares++;
        $display("FAIL tmo_fire_%0d: busy=%b err=%0d irq=%b, required 0 2 1", pass, busy_o, err_o, irq_o);
      end
    end
  endtask

  task automatic test_abort_and_param();
    bit exp;
    set_env(50, 30, -1, 0, 10, 30);
    abort_with_done = 1;
    do_start(1, $urandom, $urandom_range(1024, 1), 1);
    run_to_end(exp);
    vectors++;
    if (exp || err_o !== 3'd3 || irq_o !== 1 || m_starts != 1) begin
      miscompares++;
      $display("FAIL abort_done: err=%0d irq=%b starts=%0d, required 3 1 1", err_o, irq_o, m_starts);
    end
    vectors++;
    if (m_en_on_abort) begin miscompares++; $display("FAIL abort_en: enable high in abort cycle, required low"); end

    set_env(50, 30, -1, 0, 10, 30);
    do_start(1'($urandom), $urandom, 0, $urandom_range(5));
    run_to_end(exp);
    vectors++;
    if (exp || err_o !== 3'd4 || irq_o !== 1 || m_en_seen || m_starts != 0) begin
      miscompares++;
      $display("FAIL bad_size: err=%0d irq=%b en_seen=%b starts=%0d, required 4 1 0 0",
               err_o, irq_o, m_en_seen, m_starts);
    end
    abort_i = 1;
    @(negedge wb_clk);
    abort_i = 0;
    @(negedge wb_clk);
    vectors++;
    if (err_o !== 3'd4 || irq_o !== 1 || busy_o !== 0) begin
      miscompares++;
      $display("FAIL abort_idle: err=%0d irq=%b busy=%b, required 4 1 0", err_o, irq_o, busy_o);
    end
  endtask

  task automatic test_rst_mid_run();
    bit exp;
    int n, cnt;
    set_env(60, 30, -1, 0, 30, 60);
    do_start(1, $urandom, 256, 2);
    n = 0;
    while (m_starts == 0 && n < 20) begin run_cycle(); n++; end
    repeat (5) run_cycle();
    rst = 1;
    #1;
    vectors++;
    if ({en_rx_o, en_tx_o, blk_start_o, busy_o, irq_o, err_o, adr_o, xfer_cnt_o} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: en_rx=%b busy=%b adr=%h xfer=%0d, required all zero",
               en_rx_o, busy_o, adr_o, xfer_cnt_o);
    end
    idle_inputs();
    @(negedge wb_clk);
    rst = 0;
    @(negedge wb_clk);
    cnt = $urandom_range(2);
    set_env(60, 30, 40, 0, 20, 60);
    do_start(1'($urandom), $urandom, $urandom_range(600, 1), cnt);
    run_to_end(exp);
    vectors++;
    if (exp || err_o !== 0 || irq_o !== 1 || m_starts != cnt + 1 || xfer_cnt_o !== 27'(m_beats)) begin
      miscompares++;
      $display("FAIL rst_recover: err=%0d irq=%b starts=%0d/%0d xfer=%0d/%0d",
               err_o, irq_o, m_starts, cnt + 1, xfer_cnt_o, m_beats);
    end
  endtask

  task automatic test_random();
    bit exp, dir;
    int cnt, size;
    for (int it = 0; it < 6; it++) begin
      dir = 1'($urandom);
      cnt = $urandom_range(3);
      size = $urandom_range(1500, 1);
      set_env($urandom_range(90, 40), 30, dir ? -1 : $urandom_range(200, 8), 0, 20, 80);
      noise_start = 1;
      do_start(dir, $urandom, size, cnt);
      run_to_end(exp);
      vectors++;
      if (exp || err_o !== 0 || irq_o !== 1 || m_starts != cnt + 1) begin
        miscompares++;
        $display("FAIL rand_%0d_end: err=%0d irq=%b starts=%0d, required 0 1 %0d",
                 it, err_o, irq_o, m_starts, cnt + 1);
      end
      vectors++;
      if (xfer_cnt_o !== 27'(m_beats) || (dir && m_beats != m_total)) begin
        miscompares++;
        $display("FAIL rand_%0d_xfer: got %0d model %0d total %0d", it, xfer_cnt_o, m_beats, m_total);
      end
      vectors++;
      if (m_double != 0 || m_adr_bad != 0 || m_dir_bad != 0) begin
        miscompares++;
        $display("FAIL rand_%0d_protocol: double=%0d adr_bad=%0d dir_bad=%0d", it, m_double, m_adr_bad, m_dir_bad);
      end
    end
  endtask

  initial begin
    dir_i = 0; dma_adr_i = '0; blk_size_i = '0; blk_cnt_i = '0;
    m_dir = 0; m_adr = '0; m_total = 0; m_beats = 0; m_starts = 0; eng_cd = 0; m_out = 0;
    set_env(0, 0, -1, 0, 1, 1);
    @(negedge wb_clk);
    test_reset();
    test_rx_two_blocks();
    test_tx_prefill();
    test_crc_error();
    test_timeout();
    test_abort_and_param();
    test_rst_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
